// File: rtl/bscan_user_pkg.sv
// Shared types, field-offset helpers and constants for the BSCAN user-register bank.
package bscan_user_pkg;

    localparam int unsigned XFER_CNT_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Raw BSCANE2 outputs as one vector for the synchronizer
    typedef struct packed {
        logic update;
        logic shift;
        logic capture;
        logic sel;
        logic tdi;
        logic tck;
    } bscan_in_t;

    // Control/data sampled just before a detected TCK rise
    typedef struct packed {
        logic sel;
        logic capture;
        logic shift;
        logic tdi;
    } bscan_ctl_t;

    function automatic int unsigned chan_w(input int unsigned num_channels);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < num_channels) w = i + 1;
        end
        return w;
    endfunction

    function automatic int unsigned chan_lo(input int unsigned data_width);
        return data_width;
    endfunction

    function automatic int unsigned flag_bit(input int unsigned data_width,
                                             input int unsigned num_channels);
        return data_width + chan_w(num_channels);
    endfunction

    function automatic int unsigned dr_len(input int unsigned data_width,
                                           input int unsigned num_channels);
        return flag_bit(data_width, num_channels) + 1;
    endfunction

endpackage

// File: rtl/bscan_user_regs_if.sv
// BSCANE2 USER-chain signal bundle; master is the primitive side, slave the fabric logic.
interface bscan_user_regs_if;
    logic tck;
    logic tdi;
    logic sel;
    logic capture;
    logic shift;
    logic update;
    logic tdo;

    modport master (output tck, tdi, sel, capture, shift, update, input tdo);
    modport slave  (input tck, tdi, sel, capture, shift, update, output tdo);
endinterface

// File: rtl/bscan_sync.sv
// Synchronizes the BSCANE2 outputs into clk and produces registered edge pulses
// plus the pre-edge control sample that goes with each TCK rise.
module bscan_sync
    import bscan_user_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  bscan_in_t  raw,
    output bscan_ctl_t pre,
    output logic       tck_rise,
    output logic       update_rise,
    output logic       sel_fall
);

    bscan_in_t stage [SYNC_STAGES];
    logic      last_sel;
    logic      last_upd;

    // Edges compare the last two synced samples; update/sel edges lag one cycle
    // so the update decode lines up with the two-register TCK-to-TDO path.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            pre         <= '0;
            last_sel    <= 1'b0;
            last_upd    <= 1'b0;
            tck_rise    <= 1'b0;
            update_rise <= 1'b0;
            sel_fall    <= 1'b0;
        end else begin
            stage[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            pre         <= '{sel:     stage[SYNC_STAGES-1].sel,
                             capture: stage[SYNC_STAGES-1].capture,
                             shift:   stage[SYNC_STAGES-1].shift,
                             tdi:     stage[SYNC_STAGES-1].tdi};
            last_sel    <= stage[SYNC_STAGES-1].sel;
            last_upd    <= stage[SYNC_STAGES-1].sel & stage[SYNC_STAGES-1].update;
            tck_rise    <= stage[SYNC_STAGES-2].tck & ~stage[SYNC_STAGES-1].tck;
            update_rise <= stage[SYNC_STAGES-1].sel & stage[SYNC_STAGES-1].update & ~last_upd;
            sel_fall    <= ~stage[SYNC_STAGES-1].sel & last_sel;
        end
    end

endmodule

// File: rtl/bscan_user_regs.sv
// JTAG user-register bank: decodes USER-chain DR scans into channel writes and
// readbacks, with sticky length/address error flags and a transfer counter.
module bscan_user_regs
    import bscan_user_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    bscan_user_regs_if.slave                     jtag,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   ch_rd_i,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   ch_data_o,
    output logic                                 wr_valid,
    output logic [chan_w(NUM_CHANNELS)-1:0]      wr_chan,
    output logic                                 len_err,
    output logic                                 addr_err,
    input  logic                                 err_clr,
    output logic [XFER_CNT_W-1:0]                xfer_count
);

    localparam int unsigned CHAN_W  = chan_w(NUM_CHANNELS);
    localparam int unsigned CHAN_LO = chan_lo(DATA_WIDTH);
    localparam int unsigned FLAG    = flag_bit(DATA_WIDTH, NUM_CHANNELS);
    localparam int unsigned DR_LEN  = dr_len(DATA_WIDTH, NUM_CHANNELS);
    localparam int unsigned CNT_W   = $clog2(DR_LEN + 2);

    bscan_ctl_t pre;
    logic       tck_rise;
    logic       update_rise;
    logic       sel_fall;

    bscan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst         (rst),
        .raw         ({jtag.update, jtag.shift, jtag.capture, jtag.sel, jtag.tdi, jtag.tck}),
        .pre         (pre),
        .tck_rise    (tck_rise),
        .update_rise (update_rise),
        .sel_fall    (sel_fall)
    );

    logic [DATA_WIDTH-1:0] ch_rd [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0] ch_q  [NUM_CHANNELS];

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        assign ch_rd[k]                               = ch_rd_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign ch_data_o[k*DATA_WIDTH +: DATA_WIDTH]  = ch_q[k];
    end

    state_t                state_q, state_d;
    logic [DR_LEN-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CHAN_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CHAN_W-1:0]     wr_chan_d;
    logic [CHAN_W-1:0]     sr_chan;
    logic [XFER_CNT_W-1:0] xfer_d;
    logic                  wr_d;
    logic                  len_set;
    logic                  addr_set;
    logic                  tdo_q;

    assign sr_chan  = sr_q[CHAN_LO +: CHAN_W];
    assign jtag.tdo = tdo_q;

    // Scan sequencing and update decode; a capture always wins and reloads sr
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        wr_chan_d = wr_chan;
        xfer_d    = xfer_count;
        wr_d      = 1'b0;
        len_set   = 1'b0;
        addr_set  = 1'b0;
        if (tck_rise && pre.sel && pre.capture) begin
            state_d   = SCAN;
            sr_d      = {1'b1, rd_ptr_q, ch_rd[rd_ptr_q]};
            bit_cnt_d = '0;
        end else if (state_q == SCAN) begin
            if (update_rise) begin
                state_d = IDLE;
                if (bit_cnt_q != CNT_W'(DR_LEN)) begin
                    len_set = 1'b1;
                end else if (32'(sr_chan) >= 32'(NUM_CHANNELS)) begin
                    addr_set = 1'b1;
                end else begin
                    rd_ptr_d = sr_chan;
                    xfer_d   = xfer_count + XFER_CNT_W'(1);
                    if (sr_q[FLAG]) begin
                        wr_d      = 1'b1;
                        wr_chan_d = sr_chan;
                    end
                end
            end else if (sel_fall) begin
                state_d = IDLE;
            end else if (tck_rise && pre.sel && pre.shift) begin
                sr_d = {pre.tdi, sr_q[DR_LEN-1:1]};
                if (bit_cnt_q != CNT_W'(DR_LEN + 1)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            rd_ptr_q   <= '0;
            tdo_q      <= 1'b0;
            wr_valid   <= 1'b0;
            wr_chan    <= '0;
            len_err    <= 1'b0;
            addr_err   <= 1'b0;
            xfer_count <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) ch_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            tdo_q      <= sr_q[0];
            wr_valid   <= wr_d;
            wr_chan    <= wr_chan_d;
            len_err    <= len_set  | (len_err  & ~err_clr);
            addr_err   <= addr_set | (addr_err & ~err_clr);
            xfer_count <= xfer_d;
            if (wr_d) ch_q[wr_chan_d] <= sr_q[DATA_WIDTH-1:0];
        end
    end

endmodule
